qea_launch_ctrl: RTL and testbench

Host-side sequencer directly upstream of `QEA`, on the same clock. It streams gate-context words into the QEA context RAM and writes the |0…0⟩ initial state into the state RAM. It then pulses `i_start`, waits for `o_complete`, and streams the final state vector back out over a valid/ready port. It performs in hardware the load/start/readout sequence that the QEA benches drive by hand.

---
 rtl/qea_launch_ctrl.sv | 139 +++++++++++++
 tb/tb_qea_launch_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qea_launch_ctrl.sv
// qea_launch_ctrl: loads context/initial state into QEA, starts it, streams the result out; QEA_LAUNCH_PERF_EN adds the exec-cycle counter
module qea_launch_ctrl #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int RD_LAT                  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_cfg_valid,
  output logic                                 o_cfg_ready,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_cfg_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_cfg_ins_num,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  output logic                                 o_rd_valid,
  input  logic                                 i_rd_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
  output logic                                 o_rd_last,
  output logic                                 o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
  output logic                                 o_qea_ctx_en,
  output logic                                 o_qea_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data,
  output logic                                 o_qea_state_ena,
  output logic                                 o_qea_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_dina,
  input  logic                                 i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
  output logic                                 o_busy,
  output logic                                 o_err,
  output logic [31:0]                          o_exec_cycles
);
  localparam int W  = PE_NUM * STATE_DATA_WIDTH;
  localparam int CW = (STATE_ADDR_WIDTH > GATE_CONTEXT_ADDR_WIDTH ? STATE_ADDR_WIDTH : GATE_CONTEXT_ADDR_WIDTH) + 1;
  localparam int LW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  localparam logic [MAX_QBIT_WIDTH-1:0] QMIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] QMAX = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
  localparam logic [W-1:0] ONE_WORD = {(DATA_WIDTH'(1) << NUM_FRAC_BIT), {(W-DATA_WIDTH){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD_CTX, INIT, START, RUN, RD_ADDR, RD_WAIT, RD_OUT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, n_last, ins;
  logic [LW-1:0] wcnt;
  logic cfg_ok, accept, ctx_hs, rd_hs;

  assign cfg_ok            = i_cfg_qbit_num >= QMIN && i_cfg_qbit_num <= QMAX;
  assign accept            = state == IDLE && i_cfg_valid && cfg_ok;
  assign ctx_hs            = state == LOAD_CTX && i_ctx_valid;
  assign rd_hs             = state == RD_OUT && i_rd_ready;
  assign o_cfg_ready       = state == IDLE && !rst;
  assign o_ctx_ready       = state == LOAD_CTX;
  assign o_rd_valid        = state == RD_OUT;
  assign o_qea_start       = state == START;
  assign o_qea_ctx_wea     = o_qea_ctx_en;
  assign o_qea_state_ena   = state == INIT || state == RD_ADDR;
  assign o_qea_state_wea   = state == INIT;
  assign o_qea_state_addra = o_qea_state_ena ? cnt[STATE_ADDR_WIDTH-1:0] : '0;
  assign o_qea_state_dina  = (state == INIT && cnt == '0) ? ONE_WORD : '0;
  assign o_busy            = state != IDLE;

  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;

  // sequencing: each phase ends when its address counter reaches the last word
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (accept) state_n = i_cfg_ins_num == '0 ? INIT : LOAD_CTX;
      LOAD_CTX: if (i_ctx_valid && cnt == ins - CW'(1)) state_n = INIT;
      INIT:     if (cnt == n_last) state_n = START;
      START:    state_n = RUN;
      RUN:      if (i_qea_complete) state_n = RD_ADDR;
      RD_ADDR:  state_n = RD_WAIT;
      RD_WAIT:  if (wcnt == LW'(RD_LAT - 1)) state_n = RD_OUT;
      RD_OUT:   if (i_rd_ready) state_n = o_rd_last ? IDLE : RD_ADDR;
      default:  state_n = IDLE;
    endcase
  end

  // job parameters, shared address counter, registered context writes and readout capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      wcnt           <= '0;
      n_last         <= '0;
      ins            <= '0;
      o_err          <= 1'b0;
      o_qea_qbit_num <= '0;
      o_qea_ctx_en   <= 1'b0;
      o_qea_ctx_addr <= '0;
      o_qea_ctx_data <= '0;
      o_rd_data      <= '0;
      o_rd_last      <= 1'b0;
    end else begin
      o_err        <= state == IDLE && i_cfg_valid && !cfg_ok;
      o_qea_ctx_en <= ctx_hs;
      if (ctx_hs) begin
        o_qea_ctx_addr <= cnt[GATE_CONTEXT_ADDR_WIDTH-1:0];
        o_qea_ctx_data <= i_ctx_data;
      end
      if (accept) begin
        o_qea_qbit_num <= i_cfg_qbit_num;
        n_last         <= (CW'(1) << (i_cfg_qbit_num - QMIN)) - CW'(1);
        ins            <= CW'(i_cfg_ins_num);
        cnt            <= '0;
      end else if (ctx_hs || state == INIT)
        cnt <= state_n != state ? '0 : cnt + CW'(1);
      else if (rd_hs)
        cnt <= cnt + CW'(1);
      wcnt <= (state == RD_WAIT && state_n == RD_WAIT) ? wcnt + LW'(1) : '0;
      if (state == RD_WAIT && state_n == RD_OUT) begin
        o_rd_data <= i_qea_state_dout;
        o_rd_last <= cnt == n_last;
      end
    end
  end

`ifdef QEA_LAUNCH_PERF_EN
  // saturating count of START plus RUN cycles before complete is seen
  always_ff @(posedge clk)
    if (rst || accept)
      o_exec_cycles <= '0;
    else if ((state == START || (state == RUN && !i_qea_complete)) && o_exec_cycles != '1)
      o_exec_cycles <= o_exec_cycles + 32'd1;
`else
  assign o_exec_cycles = '0;
`endif
endmodule

// File: tb/tb_qea_launch_ctrl.sv
// tb_qea_launch_ctrl: directed checks of the QEA launch sequencer against a small QEA RAM model
module tb_qea_launch_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, i_cfg_valid, o_cfg_ready, i_ctx_valid, o_ctx_ready, o_rd_valid, i_rd_ready, o_rd_last;
  logic [5:0] i_cfg_qbit_num, o_qea_qbit_num;
  logic [16:0] i_cfg_ins_num;
  logic [63:0] i_ctx_data, o_qea_ctx_data;
  logic [255:0] o_rd_data, o_qea_state_dina, i_qea_state_dout;
  logic o_qea_start, o_qea_ctx_en, o_qea_ctx_wea, o_qea_state_ena, o_qea_state_wea;
  logic [15:0] o_qea_ctx_addr, o_qea_state_addra;
  logic i_qea_complete, o_busy, o_err;
  logic [31:0] o_exec_cycles;

  qea_launch_ctrl dut (
    .clk(clk), .rst(rst),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
    .i_cfg_qbit_num(i_cfg_qbit_num), .i_cfg_ins_num(i_cfg_ins_num),
    .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last),
    .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
    .o_qea_ctx_en(o_qea_ctx_en), .o_qea_ctx_wea(o_qea_ctx_wea),
    .o_qea_ctx_addr(o_qea_ctx_addr), .o_qea_ctx_data(o_qea_ctx_data),
    .o_qea_state_ena(o_qea_state_ena), .o_qea_state_wea(o_qea_state_wea),
    .o_qea_state_addra(o_qea_state_addra), .o_qea_state_dina(o_qea_state_dina),
    .i_qea_complete(i_qea_complete), .i_qea_state_dout(i_qea_state_dout),
    .o_busy(o_busy), .o_err(o_err), .o_exec_cycles(o_exec_cycles)
  );

  localparam logic [255:0] ONE_WORD = {32'h4000_0000, 224'd0};
`ifdef QEA_LAUNCH_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  int n_cmp = 0, n_bad = 0;
  int ctx_wr = 0, ctx_bad = 0, st_wr = 0, st_bad = 0, starts = 0, rd_en = 0;
  int ctx_base = 0, st_base = 0;
  logic [63:0] ctx_ref [0:255];

  function automatic logic [255:0] pat(input logic [15:0] a);
    return {4{{32'(a) * 32'h9E37_79B1}, {16'hBEEF, a}}};
  endfunction

  // QEA RAM model: one-cycle read latency, read data derived from the address
  always @(posedge clk)
    if (o_qea_state_ena && !o_qea_state_wea) i_qea_state_dout <= pat(o_qea_state_addra);

  // strobe monitor: counts QEA writes/reads/starts and checks write order and contents
  always @(negedge clk) begin
    if (o_qea_ctx_en) begin
      if (!o_qea_ctx_wea || o_qea_ctx_addr !== 16'(ctx_wr - ctx_base) || o_qea_ctx_data !== ctx_ref[o_qea_ctx_addr[7:0]]) ctx_bad++;
      ctx_wr++;
    end
    if (o_qea_state_ena && o_qea_state_wea) begin
      if (o_qea_state_addra !== 16'(st_wr - st_base) || o_qea_state_dina !== (o_qea_state_addra == 16'd0 ? ONE_WORD : 256'd0)) st_bad++;
      st_wr++;
    end
    if (o_qea_state_ena && !o_qea_state_wea) rd_en++;
    if (o_qea_start) starts++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [5:0] q, input logic [16:0] n);
    i_cfg_valid = 1'b1;
    i_cfg_qbit_num = q;
    i_cfg_ins_num = n;
    step;
    i_cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) step;
    n_cmp++;
    if ((|{o_cfg_ready, o_ctx_ready, o_rd_valid, o_rd_data, o_rd_last, o_qea_start, o_qea_qbit_num, o_qea_ctx_en,
           o_qea_ctx_wea, o_qea_ctx_addr, o_qea_ctx_data, o_qea_state_ena, o_qea_state_wea, o_qea_state_addra,
           o_qea_state_dina, o_busy, o_err, o_exec_cycles}) !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: some output nonzero, expected all 0");
    end
    rst = 1'b0;
    step;
    n_cmp++;
    if (o_cfg_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: cfg_ready=%b busy=%b expected 1/0", o_cfg_ready, o_busy);
    end
  endtask

  task automatic test_reject;
    for (int k = 0; k < 2; k++) begin
      int s;
      logic [5:0] q;
      q = k == 0 ? 6'd1 : 6'd19;
      s = ctx_wr + st_wr + starts + rd_en;
      cfg(q, 17'd5);
      n_cmp++;
      if (o_err !== 1'b1 || o_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reject_err q=%0d: err=%b busy=%b expected 1/0", q, o_err, o_busy);
      end
      step;
      n_cmp++;
      if (o_err !== 1'b0) begin
        n_bad++;
        $display("FAIL reject_pulse q=%0d: err=%b expected 0", q, o_err);
      end
      repeat (5) step;
      n_cmp++;
      if (ctx_wr + st_wr + starts + rd_en !== s || o_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reject_quiet q=%0d: strobes=%0d busy=%b expected %0d/0", q, ctx_wr + st_wr + starts + rd_en, o_busy, s);
      end
    end
  endtask

  task automatic test_full_job;
    int i, guard, s0, cb, sb, got, rbad, sbad;
    logic found, hs, pv, pl;
    logic [255:0] pd;
    for (int k = 0; k < 177; k++) ctx_ref[k] = {$urandom, $urandom};
    ctx_base = ctx_wr; st_base = st_wr; s0 = starts; cb = ctx_bad; sb = st_bad;
    cfg(6'd12, 17'd177);
    n_cmp++;
    if (o_qea_qbit_num !== 6'd12 || o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL full_accept: qbit=%0d busy=%b expected 12/1", o_qea_qbit_num, o_busy);
    end
    i = 0; guard = 0;
    while (i < 177 && guard < 5000) begin
      i_ctx_valid = ($urandom % 3) != 0;
      i_ctx_data = ctx_ref[i];
      hs = i_ctx_valid && o_ctx_ready;
      step;
      if (hs) i++;
      guard++;
    end
    i_ctx_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) if (o_qea_start) found = 1'b1; else step;
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL full_start_timeout: start=0 expected 1"); end
    n_cmp++;
    if (ctx_wr - ctx_base !== 177 || ctx_bad !== cb) begin
      n_bad++;
      $display("FAIL full_ctx: writes=%0d bad=%0d expected 177/0", ctx_wr - ctx_base, ctx_bad - cb);
    end
    n_cmp++;
    if (st_wr - st_base !== 1024 || st_bad !== sb) begin
      n_bad++;
      $display("FAIL full_init: writes=%0d bad=%0d expected 1024/0", st_wr - st_base, st_bad - sb);
    end
    repeat (50) step;
    i_qea_complete = 1'b1;
    step;
    i_qea_complete = 1'b0;
    n_cmp++;
    if (starts - s0 !== 1) begin n_bad++; $display("FAIL full_start_count: got %0d expected 1", starts - s0); end
    got = 0; rbad = 0; sbad = 0; pv = 1'b0; pd = '0; pl = 1'b0;
    for (int c = 0; c < 20000 && got < 1024; c++) begin
      i_rd_ready = 1'($urandom % 2);
      if (o_rd_valid) begin
        if (pv && (o_rd_data !== pd || o_rd_last !== pl)) sbad++;
        if (i_rd_ready) begin
          if (o_rd_data !== pat(16'(got)) || o_rd_last !== (got == 1023)) rbad++;
          got++;
          pv = 1'b0;
        end else begin
          pv = 1'b1; pd = o_rd_data; pl = o_rd_last;
        end
      end
      step;
    end
    i_rd_ready = 1'b0;
    n_cmp++;
    if (got !== 1024) begin n_bad++; $display("FAIL full_rd_count: got %0d expected 1024", got); end
    n_cmp++;
    if (rbad !== 0) begin n_bad++; $display("FAIL full_rd_data: bad words %0d expected 0", rbad); end
    n_cmp++;
    if (sbad !== 0) begin n_bad++; $display("FAIL full_rd_stable: changes %0d expected 0", sbad); end
    n_cmp++;
    if (o_busy !== 1'b0 || o_cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL full_idle: busy=%b cfg_ready=%b expected 0/1", o_busy, o_cfg_ready);
    end
    n_cmp++;
    if (o_exec_cycles !== 32'(PERF * 50)) begin
      n_bad++;
      $display("FAIL full_exec: got %0d expected %0d", o_exec_cycles, PERF * 50);
    end
  endtask

  task automatic test_min_job;
    int s0, sb;
    logic found;
    st_base = st_wr; s0 = starts; sb = st_bad;
    cfg(6'd2, 17'd0);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) if (o_qea_start) found = 1'b1; else step;
    n_cmp++;
    if (!found || st_wr - st_base !== 1 || st_bad !== sb) begin
      n_bad++;
      $display("FAIL min_init: start=%b writes=%0d bad=%0d expected 1/1/0", found, st_wr - st_base, st_bad - sb);
    end
    i_qea_complete = 1'b1;
    step;
    i_qea_complete = 1'b0;
    repeat (3) step;
    n_cmp++;
    if (o_busy !== 1'b1 || o_rd_valid !== 1'b0 || o_qea_state_ena !== 1'b0) begin
      n_bad++;
      $display("FAIL min_run_wait: busy=%b rd_valid=%b ena=%b expected 1/0/0", o_busy, o_rd_valid, o_qea_state_ena);
    end
    i_qea_complete = 1'b1;
    step;
    i_qea_complete = 1'b0;
    i_rd_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) if (o_rd_valid) found = 1'b1; else step;
    n_cmp++;
    if (!found || o_rd_data !== pat(16'd0) || o_rd_last !== 1'b1) begin
      n_bad++;
      $display("FAIL min_rd: valid=%b data=%h last=%b expected 1/%h/1", found, o_rd_data, o_rd_last, pat(16'd0));
    end
    step;
    i_rd_ready = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b0 || starts - s0 !== 1 || o_qea_qbit_num !== 6'd2) begin
      n_bad++;
      $display("FAIL min_done: busy=%b starts=%0d qbit=%0d expected 0/1/2", o_busy, starts - s0, o_qea_qbit_num);
    end
    n_cmp++;
    if (o_exec_cycles !== 32'(PERF * 4)) begin
      n_bad++;
      $display("FAIL min_exec: got %0d expected %0d", o_exec_cycles, PERF * 4);
    end
  endtask

  task automatic test_reset_mid_init;
    int s, s0;
    st_base = st_wr;
    cfg(6'd12, 17'd0);
    repeat (10) step;
    rst = 1'b1;
    step;
    n_cmp++;
    if ((|{o_cfg_ready, o_ctx_ready, o_rd_valid, o_rd_data, o_rd_last, o_qea_start, o_qea_qbit_num, o_qea_ctx_en,
           o_qea_ctx_wea, o_qea_ctx_addr, o_qea_ctx_data, o_qea_state_ena, o_qea_state_wea, o_qea_state_addra,
           o_qea_state_dina, o_busy, o_err, o_exec_cycles}) !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_outputs: some output nonzero, expected all 0");
    end
    s = st_wr; s0 = starts;
    repeat (2) step;
    rst = 1'b0;
    repeat (20) step;
    n_cmp++;
    if (st_wr !== s || starts !== s0 || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_quiet: writes+%0d starts+%0d busy=%b expected 0/0/0", st_wr - s, starts - s0, o_busy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; i_cfg_valid = 1'b0; i_cfg_qbit_num = '0; i_cfg_ins_num = '0;
    i_ctx_valid = 1'b0; i_ctx_data = '0; i_rd_ready = 1'b0; i_qea_complete = 1'b0;
    i_qea_state_dout = '0;
    for (int k = 0; k < 256; k++) ctx_ref[k] = '0;
    test_reset;
    test_reject;
    test_full_job;
    test_min_job;
    test_reset_mid_init;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
